// File: rtl/cjg_ex_wb.sv
// cjg_ex_wb: execute-to-writeback stage behind cjg_alu.
//
// Captures the ALU result and the c/n/v/z flags into a 2-entry skid buffer
// with a valid/ready handshake. Owns the status register (SR) and evaluates
// each instruction's condition code against it at accept time. Instructions
// whose condition fails are annulled (write enable forced low), but they still
// flow downstream so that ordering is preserved.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   in_valid / in_ready         upstream handshake
//   in_result, in_c/n/v/z       ALU result and flags
//   in_rd, in_wr_en             destination register and write enable
//   in_flag_en                  instruction updates SR when it commits
//   in_cond                     4-bit condition code
//   out_valid / out_ready       writeback handshake
//   out_result, out_rd          payload of the head entry
//   out_wr_en, out_annul        write enable (0 if annulled), annul marker
//   sr_flags                    SR as {c,n,v,z}
//   sr_load, sr_load_data       software write of SR
//   scan_in0/scan_en/test_mode  DFT hooks, no functional effect
//   scan_out0                   DFT output, tied low until scan insertion
//
// State | meaning
// ------+-------------------------------------------
// EMPTY | no entry held, out_valid = 0
// ONE   | main register holds the head entry
// FULL  | main and skid registers both hold entries

module cjg_ex_wb #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_c,
    input  logic             in_n,
    input  logic             in_v,
    input  logic             in_z,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_wr_en,
    input  logic             in_flag_en,
    input  logic [3:0]       in_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_wr_en,
    output logic             out_annul,
    output logic [3:0]       sr_flags,
    input  logic             sr_load,
    input  logic [3:0]       sr_load_data,
    input  logic             scan_in0,
    input  logic             scan_en,
    input  logic             test_mode,
    output logic             scan_out0
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state;
    logic [3:0]       sr;

    logic [WIDTH-1:0] main_result;
    logic [RA_W-1:0]  main_rd;
    logic             main_wr_en;
    logic             main_annul;

    logic [WIDTH-1:0] skid_result;
    logic [RA_W-1:0]  skid_rd;
    logic             skid_wr_en;
    logic             skid_annul;

    logic             accept;
    logic             release_ok;
    logic             cond_pass;
    logic             new_wr_en;
    logic             new_annul;

    logic             sr_c, sr_n, sr_v, sr_z;

    logic             unused_dft;

    assign sr_c = sr[3];
    assign sr_n = sr[2];
    assign sr_v = sr[1];
    assign sr_z = sr[0];

    // in_ready depends on state only, so there is no path from out_ready.
    assign in_ready   = (state != FULL);
    assign out_valid  = (state != EMPTY);
    assign accept     = in_valid & in_ready;
    assign release_ok = out_valid & out_ready;

    always_comb begin
        cond_pass = 1'b0;
        case (in_cond)
            4'd0:    cond_pass = 1'b1;
            4'd1:    cond_pass = sr_z;
            4'd2:    cond_pass = ~sr_z;
            4'd3:    cond_pass = sr_c;
            4'd4:    cond_pass = ~sr_c;
            4'd5:    cond_pass = sr_n;
            4'd6:    cond_pass = ~sr_n;
            4'd7:    cond_pass = sr_v;
            4'd8:    cond_pass = ~sr_v;
            4'd9:    cond_pass = sr_c & ~sr_z;
            4'd10:   cond_pass = ~sr_c | sr_z;
            4'd11:   cond_pass = (sr_n == sr_v);
            4'd12:   cond_pass = (sr_n != sr_v);
            4'd13:   cond_pass = ~sr_z & (sr_n == sr_v);
            4'd14:   cond_pass = sr_z | (sr_n != sr_v);
            default: cond_pass = 1'b0;
        endcase
    end

    assign new_wr_en = in_wr_en & cond_pass;
    assign new_annul = ~cond_pass;

    // A committing flag-setting instruction takes priority over a software load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= 4'b0000;
        end else if (accept && cond_pass && in_flag_en) begin
            sr <= {in_c, in_n, in_v, in_z};
        end else if (sr_load) begin
            sr <= sr_load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            main_result <= '0;
            main_rd     <= '0;
            main_wr_en  <= 1'b0;
            main_annul  <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_wr_en  <= 1'b0;
            skid_annul  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_result <= in_result;
                        main_rd     <= in_rd;
                        main_wr_en  <= new_wr_en;
                        main_annul  <= new_annul;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (accept && release_ok) begin
                        main_result <= in_result;
                        main_rd     <= in_rd;
                        main_wr_en  <= new_wr_en;
                        main_annul  <= new_annul;
                    end else if (accept) begin
                        skid_result <= in_result;
                        skid_rd     <= in_rd;
                        skid_wr_en  <= new_wr_en;
                        skid_annul  <= new_annul;
                        state       <= FULL;
                    end else if (release_ok) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (release_ok) begin
                        main_result <= skid_result;
                        main_rd     <= skid_rd;
                        main_wr_en  <= skid_wr_en;
                        main_annul  <= skid_annul;
                        state       <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_result = main_result;
    assign out_rd     = main_rd;
    assign out_wr_en  = main_wr_en;
    assign out_annul  = main_annul;
    assign sr_flags   = sr;

    assign scan_out0  = 1'b0;
    assign unused_dft = ^{scan_in0, scan_en, test_mode};

endmodule

// File: tb/tb_cjg_ex_wb.sv
module tb_cjg_ex_wb;

    localparam int WIDTH = 32;
    localparam int RA_W  = 5;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_c, in_n, in_v, in_z;
    logic [RA_W-1:0]  in_rd;
    logic             in_wr_en;
    logic             in_flag_en;
    logic [3:0]       in_cond;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [RA_W-1:0]  out_rd;
    logic             out_wr_en;
    logic             out_annul;
    logic [3:0]       sr_flags;
    logic             sr_load;
    logic [3:0]       sr_load_data;
    logic             scan_in0, scan_en, test_mode;
    logic             scan_out0;

    int checks = 0;
    int errors = 0;

    cjg_ex_wb #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result),
        .in_c(in_c), .in_n(in_n), .in_v(in_v), .in_z(in_z),
        .in_rd(in_rd), .in_wr_en(in_wr_en), .in_flag_en(in_flag_en),
        .in_cond(in_cond),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_wr_en(out_wr_en), .out_annul(out_annul),
        .sr_flags(sr_flags), .sr_load(sr_load), .sr_load_data(sr_load_data),
        .scan_in0(scan_in0), .scan_en(scan_en), .test_mode(test_mode),
        .scan_out0(scan_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                         input logic we, input logic fe, input logic [3:0] cond,
                         input logic [3:0] flags);
        in_valid   = v;
        in_result  = res;
        in_rd      = rd;
        in_wr_en   = we;
        in_flag_en = fe;
        in_cond    = cond;
        {in_c, in_n, in_v, in_z} = flags;
    endtask

    // Hand-computed pass masks: bit k = pass for condition k.
    logic [3:0]  sr_vals [6];
    logic [15:0] pass_mask [6];

    initial begin
        sr_vals[0] = 4'b0000; pass_mask[0] = 16'h2D55;
        sr_vals[1] = 4'b1000; pass_mask[1] = 16'h2B4D;
        sr_vals[2] = 4'b0100; pass_mask[2] = 16'h5535;
        sr_vals[3] = 4'b0010; pass_mask[3] = 16'h54D5;
        sr_vals[4] = 4'b0001; pass_mask[4] = 16'h4D53;
        sr_vals[5] = 4'b0110; pass_mask[5] = 16'h2CB5;

        reset = 1'b1;
        out_ready = 1'b0;
        sr_load = 1'b0;
        sr_load_data = 4'b0000;
        scan_in0 = 1'b0; scan_en = 1'b0; test_mode = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 4'b0000);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_sr", {28'd0, sr_flags}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_rd", {27'd0, out_rd}, 32'd0);
        check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("rst_annul", {31'd0, out_annul}, 32'd0);
        check("rst_scan_out0", {31'd0, scan_out0}, 32'd0);
        reset = 1'b0;

        // Streaming 1..8 at one per cycle
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, i[4:0], 1'b1, 1'b0, 4'd0, 4'b0000);
            step();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_result", out_result, i);
            check("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 4'b0000);
        step();
        check("stream_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure: three offered, two accepted
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 5'd1, 1'b1, 1'b0, 4'd0, 4'b0000);
        step();
        check("bp_first_ready", {31'd0, in_ready}, 32'd1);
        check("bp_first_result", out_result, 32'h100);
        drive(1'b1, 32'h101, 5'd2, 1'b1, 1'b0, 4'd0, 4'b0000);
        step();
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_result", out_result, 32'h100);
        drive(1'b1, 32'h102, 5'd3, 1'b1, 1'b0, 4'd0, 4'b0000);
        step();
        check("bp_third_blocked", {31'd0, in_ready}, 32'd0);
        check("bp_still_head", out_result, 32'h100);
        check("bp_head_rd", {27'd0, out_rd}, 32'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 4'b0000);
        out_ready = 1'b1;
        step();
        check("bp_second_result", out_result, 32'h101);
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_ready_after_release", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Back-to-back flag producer and EQ consumer
        drive(1'b1, 32'h0, 5'd1, 1'b1, 1'b1, 4'd0, 4'b0001);
        step();
        check("b2b_sr_z", {28'd0, sr_flags}, 32'h1);
        drive(1'b1, 32'h5, 5'd3, 1'b1, 1'b0, 4'd1, 4'b0000);
        step();
        check("eq_result", out_result, 32'h5);
        check("eq_rd", {27'd0, out_rd}, 32'd3);
        check("eq_wr_en", {31'd0, out_wr_en}, 32'd1);
        check("eq_annul", {31'd0, out_annul}, 32'd0);

        // Same with NE: annulled, and its flag_en must not touch SR
        drive(1'b1, 32'h0, 5'd1, 1'b1, 1'b1, 4'd0, 4'b0001);
        step();
        drive(1'b1, 32'h5, 5'd3, 1'b1, 1'b1, 4'd2, 4'b1000);
        step();
        check("ne_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("ne_annul", {31'd0, out_annul}, 32'd1);
        check("ne_sr_kept", {28'd0, sr_flags}, 32'h1);

        // Priority: instruction beats sr_load
        drive(1'b1, 32'h7, 5'd4, 1'b0, 1'b1, 4'd0, 4'b0100);
        sr_load = 1'b1;
        sr_load_data = 4'b1111;
        step();
        check("prio_instr_wins", {28'd0, sr_flags}, 32'h4);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 4'b0000);
        sr_load_data = 4'b1010;
        step();
        check("lone_sr_load", {28'd0, sr_flags}, 32'hA);
        sr_load = 1'b0;
        step();

        // Condition sweep
        for (int s = 0; s < 6; s++) begin
            drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 4'b0000);
            sr_load = 1'b1;
            sr_load_data = sr_vals[s];
            step();
            sr_load = 1'b0;
            check("sweep_sr", {28'd0, sr_flags}, {28'd0, sr_vals[s]});
            for (int c = 0; c < 16; c++) begin
                logic [15:0] m;
                m = pass_mask[s];
                drive(1'b1, c, 5'd7, 1'b1, 1'b0, c[3:0], 4'b0000);
                step();
                check($sformatf("sweep_annul_sr%0d_c%0d", s, c), {31'd0, out_annul}, {31'd0, ~m[c]});
                check($sformatf("sweep_wren_sr%0d_c%0d", s, c), {31'd0, out_wr_en}, {31'd0, m[c]});
            end
        end

        // Reset with buffer full (SR currently 0110)
        out_ready = 1'b0;
        drive(1'b1, 32'hA0, 5'd1, 1'b1, 1'b0, 4'd0, 4'b0000);
        step();
        drive(1'b1, 32'hA1, 5'd2, 1'b1, 1'b0, 4'd0, 4'b0000);
        step();
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        check("pre_rst_sr", {28'd0, sr_flags}, 32'h6);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready}, 32'd1);
        check("async_rst_sr", {28'd0, sr_flags}, 32'd0);
        drive(1'b1, 32'hA2, 5'd3, 1'b1, 1'b1, 4'd0, 4'b1111);
        step();
        check("rst_no_accept", {31'd0, out_valid}, 32'd0);
        check("rst_no_sr", {28'd0, sr_flags}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 4'b0000);
        step();
        check("post_rst_empty", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
